restoring_divider: RTL



---
 rtl/arith_pkg.sv | 19 +
 rtl/addsub_unit.sv | 21 ++
 rtl/restoring_divider.sv | 115 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic block set.
// Holds the sequencing state encoding, the default operand width and a
// helper that sizes iteration counters.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 6;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Generic combinational adder/subtractor.
// Ports:
//   i_a, i_b : operands (WIDTH bits)
//   i_sub    : mode, 1 = i_a - i_b, 0 = i_a + i_b
//   o_y      : result, modulo 2**WIDTH
module addsub_unit #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] w_b_inv;

  // Two's-complement subtract: invert b and inject the carry-in.
  assign w_b_inv = i_b ^ {WIDTH{i_sub}};
  assign o_y     = i_a + w_b_inv + {{(WIDTH-1){1'b0}}, i_sub};

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_start               : request, sampled when not busy (IDLE or FINISH)
//   i_dividend, i_divisor : operands, sampled with i_start
//   o_busy                : iteration in progress
//   o_done                : one-cycle strobe, results valid
//   o_quotient/remainder  : results, held until the next completion
//   o_div_by_zero         : divisor was zero (quotient all ones, rem = dividend)
module restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;   // partial remainder, always < divisor between steps
  logic [WIDTH-1:0] r_quo;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;

  // Shifted remainder needs WIDTH+1 bits; the trial's MSB is then the borrow.
  assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};

  addsub_unit #(.WIDTH(WIDTH + 1)) u_addsub (
    .i_a   (w_shift_rem),
    .i_b   ({1'b0, r_div}),
    .i_sub (1'b1),
    .o_y   (w_trial)
  );

  always_comb begin
    w_rem_nxt = w_trial[WIDTH] ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_cnt         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FINISH: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_rem <= '0;
            r_cnt <= '0;
            if (i_divisor == '0) begin
              // Zero divisor completes immediately without iterating.
              o_quotient    <= '1;
              o_remainder   <= i_dividend;
              o_div_by_zero <= 1'b1;
              o_done        <= 1'b1;
              r_state       <= FINISH;
            end else begin
              o_busy  <= 1'b1;
              r_state <= RUN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            o_quotient    <= w_quo_nxt;
            o_remainder   <= w_rem_nxt;
            o_div_by_zero <= 1'b0;
            o_done        <= 1'b1;
            o_busy        <= 1'b0;
            r_state       <= FINISH;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
